sb_rx_packet_sequencer: RTL

SB_RX_PACKET_SEQUENCER -- requirements
Module: sb_rx_packet_sequencer

---
 rtl/sb_rx_packet_sequencer.sv | 112 +++++++++++
 1 files changed

// File: rtl/sb_rx_packet_sequencer.sv
// Sideband RX packet sequencer: validates header/data parity, sequences
// header and data phases to the sideband decoder, and flags parity/timeout errors.
module sb_rx_packet_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_word_valid,
  input  logic [63:0] i_word,
  output logic        o_header_is_valid_on_bus,
  output logic        o_data_enable,
  output logic [63:0] o_word,
  output logic        o_msg_nodata_valid,
  output logic        o_busy,
  output logic        o_parity_err,
  output logic        o_timeout_err,
  output logic [7:0]  o_err_count
);

  typedef enum logic [0:0] {IDLE, WAIT_DATA} state_e;

  localparam logic [4:0] OPC_NODATA = 5'b10010;
  localparam logic [4:0] OPC_DATA   = 5'b11011;
  localparam logic [7:0] CNT_LAST   = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic        dp_q;
  logic [63:0] word_q;
  logic        hdr_q, nd_q, de_q, pe_q, te_q;
  logic [7:0]  err_cnt_q;

  logic        is_nodata, is_data, cp_ok, dp_ok;
  logic [7:0]  err_cnt_inc;

  assign is_nodata   = (i_word[4:0] == OPC_NODATA);
  assign is_data     = (i_word[4:0] == OPC_DATA);
  assign cp_ok       = (i_word[62] == ^i_word[61:0]);
  assign dp_ok       = ((^i_word) == dp_q);
  assign err_cnt_inc = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dp_q      <= 1'b0;
      word_q    <= '0;
      hdr_q     <= 1'b0;
      nd_q      <= 1'b0;
      de_q      <= 1'b0;
      pe_q      <= 1'b0;
      te_q      <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      hdr_q <= 1'b0;
      nd_q  <= 1'b0;
      de_q  <= 1'b0;
      pe_q  <= 1'b0;
      te_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          // Unknown opcodes are ignored before any parity check.
          if (i_word_valid && (is_nodata || is_data)) begin
            if (!cp_ok) begin
              pe_q      <= 1'b1;
              err_cnt_q <= err_cnt_inc;
            end else begin
              word_q <= i_word;
              hdr_q  <= 1'b1;
              if (is_nodata) begin
                nd_q <= 1'b1;
              end else begin
                dp_q    <= i_word[63];
                cnt_q   <= '0;
                state_q <= WAIT_DATA;
              end
            end
          end
        end
        WAIT_DATA: begin
          if (i_word_valid) begin
            state_q <= IDLE;
            if (dp_ok) begin
              word_q <= i_word;
              de_q   <= 1'b1;
            end else begin
              pe_q      <= 1'b1;
              err_cnt_q <= err_cnt_inc;
            end
          end else if (cnt_q == CNT_LAST) begin
            te_q      <= 1'b1;
            err_cnt_q <= err_cnt_inc;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_header_is_valid_on_bus = hdr_q;
  assign o_data_enable            = de_q;
  assign o_word                   = word_q;
  assign o_msg_nodata_valid       = nd_q;
  assign o_busy                   = (state_q == WAIT_DATA);
  assign o_parity_err             = pe_q;
  assign o_timeout_err            = te_q;
  assign o_err_count              = err_cnt_q;

endmodule
